determinant3_3_sequencer: RTL and testbench

- Computes a 3x3 signed determinant by cofactor expansion along row 0.
- Streams in 9 elements, then time-shares one external 2x2 determinant unit for the three minors, applying signs +,-,+ and accumulating.
- Sits between the matrix source and the existing 2x2 determinant datapath and holds all sequencing.
- Contains only control and the accumulator; all minor arithmetic is done by the 2x2 unit.

---
 rtl/determinant3_3_sequencer_if.sv | 29 ++
 rtl/determinant3_3_sequencer.sv | 152 +++++++++++++++
 tb/tb_determinant3_3_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/determinant3_3_sequencer_if.sv
// rtl/determinant3_3_sequencer_if.sv - signal bundle between matrix source, sequencer and 2x2 determinant unit
interface determinant3_3_sequencer_if #(
    parameter int WIDTH = 8
);
    localparam int RW = 3 * WIDTH + 3;

    logic                      start;
    logic signed [WIDTH-1:0]   data_in;
    logic                      data_valid;
    logic                      det2_start;
    logic signed [WIDTH-1:0]   det2_a;
    logic signed [WIDTH-1:0]   det2_b;
    logic signed [WIDTH-1:0]   det2_c;
    logic signed [WIDTH-1:0]   det2_d;
    logic                      det2_done;
    logic signed [2*WIDTH:0]   det2_result;
    logic signed [RW-1:0]      result;
    logic                      done;

    modport slave (
        input  start, data_in, data_valid, det2_done, det2_result,
        output det2_start, det2_a, det2_b, det2_c, det2_d, result, done
    );

    modport master (
        output start, data_in, data_valid, det2_done, det2_result,
        input  det2_start, det2_a, det2_b, det2_c, det2_d, result, done
    );
endinterface

// File: rtl/determinant3_3_sequencer.sv
// rtl/determinant3_3_sequencer.sv - 3x3 determinant by row-0 cofactor expansion over a shared 2x2 unit
module determinant3_3_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    determinant3_3_sequencer_if.slave  sq
);
    localparam int RW = 3 * WIDTH + 3;
    localparam int PW = 3 * WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_ACCUM,
        S_FINISH
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic signed [WIDTH-1:0] r_m [0:8];
    logic [3:0]              r_cnt;
    logic [1:0]              r_k;
    logic                    r_guard;
    logic signed [RW-1:0]    r_acc;
    logic signed [RW-1:0]    r_result;
    logic signed [WIDTH-1:0] r_a;
    logic signed [WIDTH-1:0] r_b;
    logic signed [WIDTH-1:0] r_c;
    logic signed [WIDTH-1:0] r_d;
    logic                    w_last_capture;
    logic                    w_done;
    logic                    w_det2_start;
    logic signed [WIDTH-1:0] w_mk;
    logic signed [PW-1:0]    w_prod;
    logic signed [RW-1:0]    w_term;

    // the ninth element arrives this cycle; it is forwarded straight into the k=0 operands
    assign w_last_capture = (r_state == S_LOAD) && sq.data_valid && (r_cnt == 4'd8);

    // row-0 cofactor multiplier for the current minor
    always_comb begin
        case (r_k)
            2'd0:    w_mk = r_m[0];
            2'd1:    w_mk = r_m[1];
            default: w_mk = r_m[2];
        endcase
    end

    // both factors widened to the product width so the multiply is exact
    assign w_prod = $signed({{(PW-WIDTH){w_mk[WIDTH-1]}}, w_mk})
                  * $signed({{(PW-2*WIDTH-1){sq.det2_result[2*WIDTH]}}, sq.det2_result});
    assign w_term = {{(RW-PW){w_prod[PW-1]}}, w_prod};

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and handshake outputs; the first WAIT cycle ignores det2_done
    always_comb begin
        w_next       = r_state;
        w_done       = 1'b0;
        w_det2_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_done = 1'b1;
                if (sq.start) w_next = S_LOAD;
            end
            S_LOAD:   if (w_last_capture) w_next = S_ISSUE;
            S_ISSUE: begin
                w_det2_start = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT:   if (!r_guard && sq.det2_done) w_next = S_ACCUM;
            S_ACCUM:  w_next = (r_k == 2'd2) ? S_FINISH : S_ISSUE;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // element capture, operand staging, guard flag and signed accumulation
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= 4'd0;
            r_k      <= 2'd0;
            r_guard  <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            for (int i = 0; i < 9; i++) r_m[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sq.start) begin
                        r_acc <= '0;
                        r_cnt <= 4'd0;
                        r_k   <= 2'd0;
                    end
                end
                S_LOAD: begin
                    if (sq.data_valid) begin
                        r_m[r_cnt] <= sq.data_in;
                        r_cnt      <= r_cnt + 4'd1;
                    end
                    if (w_last_capture) begin
                        r_a <= r_m[4];
                        r_b <= r_m[5];
                        r_c <= r_m[7];
                        r_d <= sq.data_in;
                    end
                end
                S_ISSUE: r_guard <= 1'b1;
                S_WAIT:  r_guard <= 1'b0;
                S_ACCUM: begin
                    r_acc <= (r_k == 2'd1) ? (r_acc - w_term) : (r_acc + w_term);
                    if (r_k == 2'd0) begin
                        r_a <= r_m[3];
                        r_b <= r_m[5];
                        r_c <= r_m[6];
                        r_d <= r_m[8];
                    end else if (r_k == 2'd1) begin
                        r_a <= r_m[3];
                        r_b <= r_m[4];
                        r_c <= r_m[6];
                        r_d <= r_m[7];
                    end
                    if (r_k != 2'd2) r_k <= r_k + 2'd1;
                end
                S_FINISH: r_result <= r_acc;
                default: ;
            endcase
        end
    end

    assign sq.det2_start = w_det2_start;
    assign sq.det2_a     = r_a;
    assign sq.det2_b     = r_b;
    assign sq.det2_c     = r_c;
    assign sq.det2_d     = r_d;
    assign sq.result     = r_result;
    assign sq.done       = w_done;
endmodule

// File: tb/tb_determinant3_3_sequencer.sv
// tb/tb_determinant3_3_sequencer.sv - self-checking bench with 2x2 unit stub and Sarrus reference model
module tb_determinant3_3_sequencer;
    localparam int WIDTH = 8;
    localparam int RW    = 3 * WIDTH + 3;

    typedef logic [8:0][7:0] mat_t;
    typedef struct {
        mat_t   m;
        longint exp;
        int     lat;
        int     gaps;
        bit     noise;
        bit     hold;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    determinant3_3_sequencer_if #(.WIDTH(WIDTH)) sq();
    determinant3_3_sequencer #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .sq    (sq)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int                      stub_lat  = 3;
    bit                      stub_hold = 1'b0;
    int                      stub_cnt  = 0;
    int                      pulses    = 0;
    logic signed [2*WIDTH:0] stub_res  = '0;
    logic signed [2*WIDTH:0] stub_pend = '0;
    logic [31:0]             ops_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // 2x2 unit stub: done drops for a guard cycle plus stub_lat cycles, or stays high over the guard in hold mode
    always @(posedge clock) begin
        if (reset) begin
            stub_cnt <= 0;
        end else if (sq.det2_start) begin
            stub_cnt  <= stub_lat + 1;
            stub_pend <= 17'(int'(sq.det2_a) * int'(sq.det2_d) - int'(sq.det2_b) * int'(sq.det2_c));
            pulses    <= pulses + 1;
            ops_q.push_back({sq.det2_a, sq.det2_b, sq.det2_c, sq.det2_d});
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_res <= stub_pend;
        end
    end

    assign sq.det2_done   = (stub_cnt == 0) || (stub_hold && stub_cnt == stub_lat + 1);
    assign sq.det2_result = stub_res;

    function automatic mat_t mk(input int a0, input int a1, input int a2, input int a3, input int a4,
                                input int a5, input int a6, input int a7, input int a8);
        mat_t r;
        r[0] = a0[7:0]; r[1] = a1[7:0]; r[2] = a2[7:0];
        r[3] = a3[7:0]; r[4] = a4[7:0]; r[5] = a5[7:0];
        r[6] = a6[7:0]; r[7] = a7[7:0]; r[8] = a8[7:0];
        return r;
    endfunction

    function automatic longint det3(input mat_t m);
        longint e[9];
        for (int i = 0; i < 9; i++) e[i] = longint'($signed(m[i]));
        return e[0]*e[4]*e[8] + e[1]*e[5]*e[6] + e[2]*e[3]*e[7]
             - e[2]*e[4]*e[6] - e[1]*e[3]*e[8] - e[0]*e[5]*e[7];
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_det(input mat_t m, input int gaps, input bit noise,
                           output int lat_cyc, output bit ok);
        int t0;
        int n;
        @(negedge clock);
        sq.start      = 1'b1;
        sq.data_valid = noise;
        sq.data_in    = 8'sh55;
        @(negedge clock);
        t0            = cyc;
        sq.start      = 1'b0;
        sq.data_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (gaps > 0 && i > 0) begin
                n = $urandom_range(gaps, 1);
                repeat (n) begin
                    sq.data_valid = 1'b0;
                    sq.start      = noise;
                    sq.data_in    = 8'sh7f;
                    @(negedge clock);
                end
                sq.start = 1'b0;
            end
            sq.data_valid = 1'b1;
            sq.data_in    = m[i];
            @(negedge clock);
        end
        sq.data_valid = noise;
        sq.start      = noise;
        sq.data_in    = 8'sh81;
        @(negedge clock);
        sq.data_valid = 1'b0;
        sq.start      = 1'b0;
        ok = 1'b0;
        for (int j = 0; j < 500; j++) begin
            sq.start = (noise && j == 3);
            if (sq.done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        sq.start = 1'b0;
        lat_cyc  = cyc - t0;
    endtask

    task automatic do_run(input string name, input mat_t m, input longint exp, input int gaps,
                          input bit noise, input bit chk_lat);
        int p0;
        int q0;
        int lat_cyc;
        int c0;
        int c1;
        bit ok;
        logic [31:0] want;
        p0 = pulses;
        q0 = ops_q.size();
        run_det(m, gaps, noise, lat_cyc, ok);
        check({name, "_done"}, longint'(ok), 1);
        check({name, "_result"}, longint'(sq.result), exp);
        check({name, "_pulses"}, longint'(pulses - p0), 3);
        if (chk_lat) check({name, "_latency"}, longint'(lat_cyc), longint'(22 + 3 * stub_lat));
        for (int k = 0; k < 3; k++) begin
            c0   = (k == 0) ? 1 : 0;
            c1   = (k == 2) ? 1 : 2;
            want = {m[3 + c0], m[3 + c1], m[6 + c0], m[6 + c1]};
            if (ops_q.size() > q0 + k)
                check($sformatf("%s_ops%0d", name, k), longint'(ops_q[q0 + k]), longint'(want));
            else
                check($sformatf("%s_ops%0d_missing", name, k), longint'(ops_q.size()), longint'(q0 + k + 1));
        end
    endtask

    initial begin
        vec_t vecs[6];
        mat_t m;
        int   p0;
        int   p1;
        bit   seen;

        sq.start      = 1'b0;
        sq.data_valid = 1'b0;
        sq.data_in    = '0;
        reset         = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_done", longint'(sq.done), 1);
        check("reset_result", longint'(sq.result), 0);
        check("reset_det2_start", longint'(sq.det2_start), 0);
        check("reset_ops", longint'({sq.det2_a, sq.det2_b, sq.det2_c, sq.det2_d}), 0);
        reset = 1'b0;

        vecs[0] = '{mk(1,0,0, 0,1,0, 0,0,1),               1, 3, 0, 1'b0, 1'b0};
        vecs[1] = '{mk(1,2,3, 0,1,4, 5,6,0),               1, 2, 0, 1'b0, 1'b0};
        vecs[2] = '{mk(-128,0,0, 0,-128,0, 0,0,-128), -2097152, 1, 0, 1'b0, 1'b0};
        vecs[3] = '{mk(-128,-128,-128, -128,-128,-128, -128,-128,-128), 0, 5, 0, 1'b0, 1'b0};
        vecs[4] = '{mk(1,2,3, 0,1,4, 5,6,0),               1, 2, 3, 1'b1, 1'b0};
        vecs[5] = '{mk(2,-1,0, 1,3,2, 0,1,4),             24, 2, 0, 1'b0, 1'b1};

        for (int i = 0; i < 6; i++) begin
            stub_lat  = vecs[i].lat;
            stub_hold = vecs[i].hold;
            do_run($sformatf("vec%0d", i), vecs[i].m, vecs[i].exp, vecs[i].gaps,
                   vecs[i].noise, (vecs[i].gaps == 0 && !vecs[i].noise));
        end

        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 9; i++) m[i] = 8'($urandom);
            stub_lat  = $urandom_range(4, 1);
            stub_hold = 1'($urandom_range(1, 0));
            do_run($sformatf("rnd%0d", r), m, det3(m), $urandom_range(3, 0),
                   1'($urandom_range(1, 0)), 1'b0);
        end

        stub_lat  = 4;
        stub_hold = 1'b0;
        do_run("pre_reset", mk(1,0,0, 0,1,0, 0,0,1), 1, 0, 1'b0, 1'b0);
        p0 = pulses;
        @(negedge clock);
        sq.start = 1'b1;
        @(negedge clock);
        sq.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sq.data_valid = 1'b1;
            sq.data_in    = 8'(i + 2);
            @(negedge clock);
        end
        sq.data_valid = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 100; j++) begin
            if (pulses >= p0 + 2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("reset_wait_k1_reached", longint'(seen), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_done", longint'(sq.done), 1);
        check("midreset_result", longint'(sq.result), 0);
        check("midreset_det2_start", longint'(sq.det2_start), 0);
        p1 = pulses;
        repeat (20) @(negedge clock);
        check("midreset_no_pulses", longint'(pulses - p1), 0);
        check("midreset_idle", longint'(sq.done), 1);
        do_run("post_reset", mk(1,2,3, 0,1,4, 5,6,0), 1, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
